// File: rtl/shift_frame_unit.sv
// Configurable serial/parallel shift engine with frame counter and a
// captured-word output guarded by a valid/ack handshake and overrun flag.
module shift_frame_unit #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] pdata_in,
   input  logic             clr,
   input  logic             frame_ack,
   output logic [WIDTH-1:0] shreg,
   output logic             sout,
   output logic [7:0]       bit_cnt,
   output logic [WIDTH-1:0] frame_data,
   output logic             frame_valid,
   output logic             overrun
);

   localparam logic [1:0] MODE_SHL  = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_ROL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Last count value of a frame; the shift that finds the counter here
   // wraps it and completes the frame.
   localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sout_q, sout_d;
   logic [7:0]       bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] frame_data_q, frame_data_d;
   logic             frame_valid_q, frame_valid_d;
   logic             overrun_q, overrun_d;

   logic is_shift;
   logic is_rotate;
   logic is_load;
   logic frame_done;

   assign is_shift   = en && (mode == MODE_SHL || mode == MODE_SHR);
   assign is_rotate  = en && (mode == MODE_ROL);
   assign is_load    = en && (mode == MODE_LOAD);
   assign frame_done = is_shift && (bit_cnt_q >= LAST_CNT);

   // Next-state: clear beats load beats shift/rotate beats hold; the ack
   // clear of frame_valid works even while the datapath holds.
   always_comb begin
      // NOTE: every next-state value starts from its current value so no
      // path through this block leaves a signal unassigned (no latches).
      shreg_d       = shreg_q;
      sout_d        = sout_q;
      bit_cnt_d     = bit_cnt_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = frame_valid_q;
      overrun_d     = overrun_q;

      if (clr) begin
         // frame_data deliberately survives a clear.
         shreg_d       = '0;
         sout_d        = 1'b0;
         bit_cnt_d     = '0;
         frame_valid_d = 1'b0;
         overrun_d     = 1'b0;
      end else begin
         if (is_load) begin
            shreg_d   = pdata_in;
            bit_cnt_d = '0;
         end else if (is_shift && mode == MODE_SHL) begin
            shreg_d = {shreg_q[WIDTH-2:0], sin};
            sout_d  = shreg_q[WIDTH-1];
         end else if (is_shift) begin
            shreg_d = {sin, shreg_q[WIDTH-1:1]};
            sout_d  = shreg_q[0];
         end else if (is_rotate) begin
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            sout_d  = shreg_q[WIDTH-1];
         end

         if (is_shift) begin
            bit_cnt_d = frame_done ? 8'd0 : bit_cnt_q + 8'd1;
         end

         if (frame_done) begin
            // Newest word wins; an ack on this same edge consumes the old
            // word, so only an unacknowledged one counts as overrun.
            frame_data_d  = shreg_d;
            frame_valid_d = 1'b1;
            if (frame_valid_q && !frame_ack) begin
               overrun_d = 1'b1;
            end
         end else if (frame_ack) begin
            frame_valid_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         shreg_q       <= '0;
         sout_q        <= 1'b0;
         bit_cnt_q     <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         shreg_q       <= shreg_d;
         sout_q        <= sout_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   assign shreg       = shreg_q;
   assign sout        = sout_q;
   assign bit_cnt     = bit_cnt_q;
   assign frame_data  = frame_data_q;
   assign frame_valid = frame_valid_q;
   assign overrun     = overrun_q;

endmodule

// File: doc/shift_frame_unit.md
# shift_frame_unit

Parametrised serial/parallel shift engine for the Tiny Tapeout user tile. It generalises the fixed 8-bit serial-in shift register to a configurable width. It adds left/right shift, rotate and parallel-load modes, a frame counter, and a captured-word output with a valid/ack handshake and overrun detection. It sits between the dedicated input pins (serial bit source) and the bidirectional IO logic, which consumes captured frames.

## Interface
- WIDTH, 8: shift register width; legal range 2..32.
- FRAME_LEN, 8: shifts per frame; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low. Single clock domain.
- en  in  1  advance enable; when 0 the datapath holds.
- mode  in  2  00 shift-left (sin→bit0), 01 shift-right (sin→bit WIDTH-1), 10 rotate-left, 11 parallel load.
- sin  in  1  serial input bit.
- pdata_in  in  WIDTH  parallel load value.
- clr  in  1  synchronous clear.
- frame_ack  in  1  consumer acknowledge of frame_data.
- shreg  out  WIDTH  current register contents.
- sout  out  1  last bit shifted or rotated out, registered.
- bit_cnt  out  8  shifts taken in the current frame, range 0..FRAME_LEN-1.
- frame_data  out  WIDTH  captured word.
- frame_valid  out  1  frame_data holds an unacknowledged word (level).
- overrun  out  1  sticky flag: a frame completed while frame_valid was still set.

## Operation
- Reset (rst_n=0): shreg=0, sout=0, bit_cnt=0, frame_data=0, frame_valid=0, overrun=0. The reset takes effect immediately and aborts any partial frame.
- Per-edge priority: clr, then en with mode 11 (load), then en with mode 00/01/10 (shift/rotate), then hold.
- clr=1: shreg, bit_cnt, sout, frame_valid and overrun all go to 0. frame_data holds. clr acts regardless of en.
- Load: shreg<=pdata_in; bit_cnt<=0; sout holds; no frame event.
- Shift-left: shreg<={shreg[WIDTH-2:0],sin}, sout<=shreg[WIDTH-1].
- Shift-right: shreg<={sin,shreg[WIDTH-1:1]}, sout<=shreg[0].
- Rotate-left: shreg<={shreg[WIDTH-2:0],shreg[WIDTH-1]}, sout<=shreg[WIDTH-1]. Rotate does not change bit_cnt and never completes a frame.
- Frame counting applies to shift-left and shift-right only:
  - If bit_cnt<FRAME_LEN-1, bit_cnt increments.
  - Otherwise bit_cnt wraps to 0 and the frame completes: frame_data<=the new shreg value (post-shift) and frame_valid<=1.
  - If frame_valid was already 1 and frame_ack is 0 on that edge, overrun<=1. frame_data is overwritten either way (newest wins).
- Handshake: frame_valid clears on an edge where frame_ack=1 and no frame completes. Ack and completion on the same edge: valid stays 1, new data is captured, overrun is not set. frame_ack while frame_valid=0 is ignored.
- overrun clears only via clr or reset.
- Changing mode mid-frame is legal; bit_cnt carries on across left/right changes.

## Timing
- All outputs are registered. shreg, sout and bit_cnt reflect an edge's inputs immediately after that edge.
- frame_valid and frame_data update on the same edge as the completing shift (zero extra latency).
- Maximum throughput: one bit per cycle. With FRAME_LEN=1, a frame completes on every shift.
- en=0: no state changes except the frame_ack clear of frame_valid, which still works.

## Test plan
- Shift-left: WIDTH=8, FRAME_LEN=8, en=1, mode=00, sin=1,0,1,1,0,0,1,0. Expect shreg=0xB2 after the 8th edge, frame_data=0xB2, frame_valid=1, bit_cnt=0.
- Shift-right: same bits with mode=01. Expect shreg=frame_data=0x4D, frame_valid=1.
- Load and rotate: load 0x81, then one rotate. Expect shreg=0x03, sout=1, bit_cnt=0, frame_valid unchanged.
- Overrun:
  - Complete two frames with no ack. Expect overrun=1 and frame_data equal to the second word.
  - Then frame_ack=1 for one cycle. Expect frame_valid=0 and overrun still 1.
  - Then clr. Expect overrun=0.
- Simultaneous events: frame_ack=1 on the same edge as a frame completion. Expect frame_valid=1, new data captured, overrun=0.
- Reset mid-frame: drop rst_n asynchronously after 5 shifts. Expect all outputs 0 without waiting for an edge. After release, a full 8-bit frame is needed before frame_valid rises.
